trigger_link_formatter: RTL and testbench

//  Formats cluster-finder output into the two 56-bit trigger-link payloads (right/left)

---
 rtl/trigger_link_formatter_pkg.sv | 28 ++
 rtl/trigger_link_formatter_cluster_packer.sv | 33 +++
 rtl/trigger_link_formatter.sv | 196 +++++++++++++++++++
 tb/tb_trigger_link_formatter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_link_formatter_pkg.sv
// Shared constants, state encoding and cluster helpers for the trigger-link formatter.
package trigger_link_formatter_pkg;

    localparam int NCLUSTERS_IN     = 16;
    localparam int NSLOTS           = 8;
    localparam int CLUSTER_W        = 14;
    localparam int ADR_W            = 11;
    localparam int LINK_W           = 56;
    localparam int CNT_W            = 5;
    localparam int BX_W             = 12;
    localparam int SYNC_BX_DEF      = 64;
    localparam int BX_PER_ORBIT_DEF = 3564;

    localparam logic [ADR_W-1:0]     ADR_MAX         = 11'd1536;
    localparam logic [CLUSTER_W-1:0] INVALID_CLUSTER = 14'h07FE;
    localparam logic [CLUSTER_W-1:0] SYNC_WORD       = 14'h2AAA;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_RUN  = 2'd1,
        ST_TEST = 2'd2
    } link_state_e;

    function automatic logic cluster_valid(input logic [ADR_W-1:0] adr);
        return (adr < ADR_MAX);
    endfunction

endpackage

// File: rtl/trigger_link_formatter_cluster_packer.sv
// Combinational 16->8 selector: keeps the first eight valid clusters in input order
// and reports the total number of valid inputs.
module trigger_link_formatter_cluster_packer
    import trigger_link_formatter_pkg::*;
(
    input  logic [NCLUSTERS_IN*CLUSTER_W-1:0] clusters,
    input  logic [NCLUSTERS_IN-1:0]           valid_mask,
    output logic [NSLOTS-1:0][CLUSTER_W-1:0]  slots,
    output logic [CNT_W-1:0]                  count
);

    logic [CNT_W-1:0] pos_s;

    // Walk inputs lowest index first; each valid one lands in the next free slot
    always_comb begin
        slots = {NSLOTS{INVALID_CLUSTER}};
        pos_s = 5'd0;
        for (int k = 0; k < NCLUSTERS_IN; k++) begin
            if (valid_mask[k]) begin
                if (pos_s < 5'd8) begin
                    slots[pos_s[2:0]] = clusters[k*CLUSTER_W +: CLUSTER_W];
                    pos_s = pos_s + 5'd1;
                end else begin
                    pos_s = pos_s + 5'd1;
                end
            end else begin
                pos_s = pos_s;
            end
        end
        count = pos_s;
    end

endmodule

// File: rtl/trigger_link_formatter.sv
// Trigger-link formatter: sync/run/test FSM, BX counter and a two-stage pipeline
// producing the right/left 56-bit link payloads.
module trigger_link_formatter
    import trigger_link_formatter_pkg::*;
#(
    parameter int SYNC_BX      = SYNC_BX_DEF,
    parameter int BX_PER_ORBIT = BX_PER_ORBIT_DEF
) (
    input  logic                              clk_40,
    input  logic                              reset_n,
    input  logic [NCLUSTERS_IN*CLUSTER_W-1:0] clusters_i,
    input  logic                              overflow_i,
    input  logic                              bc0_i,
    input  logic                              test_mode_i,
    output logic [LINK_W-1:0]                 link_r_o,
    output logic [LINK_W-1:0]                 link_l_o,
    output logic                              overflow_o,
    output logic [CNT_W-1:0]                  cluster_count_o,
    output logic                              bc0_o,
    output logic                              sync_done_o
);

    localparam int                SYNC_CW   = $clog2(SYNC_BX + 1);
    localparam logic [SYNC_CW-1:0] SYNC_LAST = SYNC_CW'(SYNC_BX - 1);
    localparam logic [BX_W-1:0]    BX_LAST   = BX_W'(BX_PER_ORBIT - 1);

    link_state_e          state_r, state_nxt_s;
    logic [SYNC_CW-1:0]   sync_cnt_r;
    logic                 sync_cnt_en_s;
    logic [BX_W-1:0]      bx_cnt_r;
    logic [NCLUSTERS_IN-1:0] valid_mask_s;

    logic                              s1_vld_r;
    link_state_e                       s1_mode_r;
    logic [NCLUSTERS_IN*CLUSTER_W-1:0] s1_clusters_r;
    logic [NCLUSTERS_IN-1:0]           s1_valid_r;
    logic                              s1_ovf_r;
    logic                              s1_bc0_r;
    logic [BX_W-1:0]                   s1_bx_r;

    logic [NSLOTS-1:0][CLUSTER_W-1:0] slots_s;
    logic [CNT_W-1:0]                 count_s;
    logic [LINK_W-1:0]                link_r_nxt_s, link_l_nxt_s;
    logic                             ovf_nxt_s, sync_done_nxt_s;
    logic [CNT_W-1:0]                 count_nxt_s;

    // FSM state register
    always_ff @(posedge clk_40 or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_SYNC;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_SYNC: begin
                if (sync_cnt_r == SYNC_LAST) begin
                    state_nxt_s = test_mode_i ? ST_TEST : ST_RUN;
                end else begin
                    state_nxt_s = ST_SYNC;
                end
            end
            ST_RUN:  state_nxt_s = test_mode_i ? ST_TEST : ST_RUN;
            ST_TEST: state_nxt_s = test_mode_i ? ST_TEST : ST_RUN;
            default: state_nxt_s = ST_SYNC;
        endcase
    end

    // FSM outputs
    always_comb begin
        sync_cnt_en_s = 1'b0;
        case (state_r)
            ST_SYNC: sync_cnt_en_s = 1'b1;
            default: sync_cnt_en_s = 1'b0;
        endcase
    end

    // Sync-phase frame counter; holds once the link leaves SYNC
    always_ff @(posedge clk_40 or negedge reset_n) begin
        if (!reset_n) begin
            sync_cnt_r <= '0;
        end else if (sync_cnt_en_s) begin
            sync_cnt_r <= sync_cnt_r + SYNC_CW'(1);
        end else begin
            sync_cnt_r <= sync_cnt_r;
        end
    end

    // BX counter: bc0 takes priority over the orbit wrap
    always_ff @(posedge clk_40 or negedge reset_n) begin
        if (!reset_n) begin
            bx_cnt_r <= 12'd0;
        end else if (bc0_i) begin
            bx_cnt_r <= 12'd0;
        end else if (bx_cnt_r == BX_LAST) begin
            bx_cnt_r <= 12'd0;
        end else begin
            bx_cnt_r <= bx_cnt_r + 12'd1;
        end
    end

    // Per-input validity from the address field
    always_comb begin
        valid_mask_s = '0;
        for (int k = 0; k < NCLUSTERS_IN; k++) begin
            valid_mask_s[k] = cluster_valid(clusters_i[k*CLUSTER_W +: ADR_W]);
        end
    end

    // Stage 1: capture the frame with the mode and BX it belongs to
    always_ff @(posedge clk_40 or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld_r      <= 1'b0;
            s1_mode_r     <= ST_SYNC;
            s1_clusters_r <= '0;
            s1_valid_r    <= '0;
            s1_ovf_r      <= 1'b0;
            s1_bc0_r      <= 1'b0;
            s1_bx_r       <= 12'd0;
        end else begin
            s1_vld_r      <= 1'b1;
            s1_mode_r     <= state_r;
            s1_clusters_r <= clusters_i;
            s1_valid_r    <= valid_mask_s;
            s1_ovf_r      <= overflow_i;
            s1_bc0_r      <= bc0_i;
            s1_bx_r       <= bx_cnt_r;
        end
    end

    trigger_link_formatter_cluster_packer u_packer (
        .clusters   (s1_clusters_r),
        .valid_mask (s1_valid_r),
        .slots      (slots_s),
        .count      (count_s)
    );

    // Payload select; the first frame after reset has no captured data and stays blank
    always_comb begin
        link_r_nxt_s    = '0;
        link_l_nxt_s    = '0;
        ovf_nxt_s       = 1'b0;
        sync_done_nxt_s = 1'b0;
        count_nxt_s     = 5'd0;
        if (s1_vld_r) begin
            count_nxt_s = count_s;
            case (s1_mode_r)
                ST_SYNC: begin
                    link_r_nxt_s = {4{SYNC_WORD}};
                    link_l_nxt_s = {4{SYNC_WORD}};
                end
                ST_RUN: begin
                    link_r_nxt_s    = slots_s[3:0];
                    link_l_nxt_s    = slots_s[7:4];
                    ovf_nxt_s       = s1_ovf_r | (count_s > 5'd8);
                    sync_done_nxt_s = 1'b1;
                end
                ST_TEST: begin
                    link_r_nxt_s    = {4{2'b00, s1_bx_r}};
                    link_l_nxt_s    = {4{2'b00, s1_bx_r}};
                    sync_done_nxt_s = 1'b1;
                end
                default: begin
                    link_r_nxt_s = '0;
                    link_l_nxt_s = '0;
                end
            endcase
        end else begin
            count_nxt_s = 5'd0;
        end
    end

    // Stage 2: registered outputs
    always_ff @(posedge clk_40 or negedge reset_n) begin
        if (!reset_n) begin
            link_r_o        <= '0;
            link_l_o        <= '0;
            overflow_o      <= 1'b0;
            cluster_count_o <= 5'd0;
            bc0_o           <= 1'b0;
            sync_done_o     <= 1'b0;
        end else begin
            link_r_o        <= link_r_nxt_s;
            link_l_o        <= link_l_nxt_s;
            overflow_o      <= ovf_nxt_s;
            cluster_count_o <= count_nxt_s;
            bc0_o           <= s1_bc0_r;
            sync_done_o     <= sync_done_nxt_s;
        end
    end

endmodule

// File: tb/tb_trigger_link_formatter.sv
// Randomised self-checking bench for trigger_link_formatter with a frame-level reference model.
module tb_trigger_link_formatter;

    logic         clk_40 = 1'b0;
    logic         reset_n = 1'b0;
    logic [223:0] clusters_i;
    logic         overflow_i, bc0_i, test_mode_i;
    logic [55:0]  link_r_o, link_l_o;
    logic         overflow_o, bc0_o, sync_done_o;
    logic [4:0]   cluster_count_o;

    always #5 clk_40 = ~clk_40;

    trigger_link_formatter dut (
        .clk_40          (clk_40),
        .reset_n         (reset_n),
        .clusters_i      (clusters_i),
        .overflow_i      (overflow_i),
        .bc0_i           (bc0_i),
        .test_mode_i     (test_mode_i),
        .link_r_o        (link_r_o),
        .link_l_o        (link_l_o),
        .overflow_o      (overflow_o),
        .cluster_count_o (cluster_count_o),
        .bc0_o           (bc0_o),
        .sync_done_o     (sync_done_o)
    );

    typedef struct packed {
        logic [55:0] lr;
        logic [55:0] ll;
        logic        ovf;
        logic [4:0]  cnt;
        logic        bc0;
        logic        sd;
    } frame_t;

    int     errors = 0;
    int     checks = 0;
    frame_t exp_s1, exp_out;
    int     mst, msync, mbx;   // mode 0=sync 1=run 2=test, sync frames sent, BX number
    logic   tm;
    logic [223:0] all_inv;

    task automatic chk(input string name, input logic [55:0] act, input logic [55:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic frame_t model_frame(input logic [223:0] cl, input logic ovf,
                                           input logic bc0, input int mode, input int bx);
        logic [13:0] slot [8];
        logic [13:0] w;
        int n;
        frame_t f;
        n = 0;
        for (int j = 0; j < 8; j++) slot[j] = 14'h07FE;
        for (int k = 0; k < 16; k++) begin
            w = cl[k*14 +: 14];
            if (w[10:0] < 11'd1536) begin
                if (n < 8) slot[n] = w;
                n++;
            end
        end
        f.cnt = 5'(n);
        f.bc0 = bc0;
        if (mode == 0) begin
            f.lr = {4{14'h2AAA}}; f.ll = {4{14'h2AAA}}; f.ovf = 1'b0; f.sd = 1'b0;
        end else if (mode == 1) begin
            f.lr = {slot[3], slot[2], slot[1], slot[0]};
            f.ll = {slot[7], slot[6], slot[5], slot[4]};
            f.ovf = ovf || (n > 8);
            f.sd = 1'b1;
        end else begin
            w = {2'b00, 12'(bx)};
            f.lr = {4{w}}; f.ll = {4{w}}; f.ovf = 1'b0; f.sd = 1'b1;
        end
        return f;
    endfunction

    function automatic logic [223:0] rand_clusters(input int pct_valid);
        logic [223:0] r;
        logic [10:0]  adr;
        for (int k = 0; k < 16; k++) begin
            if (int'($urandom_range(0, 99)) < pct_valid) adr = 11'($urandom_range(0, 1535));
            else adr = 11'($urandom_range(1536, 2047));
            r[k*14 +: 14] = {3'($urandom), adr};
        end
        return r;
    endfunction

    task automatic model_reset();
        exp_s1 = '0; exp_out = '0; mst = 0; msync = 0; mbx = 0;
    endtask

    // Drive one BX, advance the model across the edge, then compare at the next falling edge
    task automatic run_cycle(input logic [223:0] cl, input logic ovf, input logic bc0, input logic t);
        frame_t f;
        clusters_i = cl; overflow_i = ovf; bc0_i = bc0; test_mode_i = t;
        f = model_frame(cl, ovf, bc0, mst, mbx);
        exp_out = exp_s1;
        exp_s1  = f;
        if (mst == 0) begin
            if (msync == 63) mst = t ? 2 : 1;
            msync++;
        end else if (mst == 1 && t) mst = 2;
        else if (mst == 2 && !t) mst = 1;
        mbx = bc0 ? 0 : ((mbx == 3563) ? 0 : mbx + 1);
        @(negedge clk_40);
        chk("link_r", link_r_o, exp_out.lr);
        chk("link_l", link_l_o, exp_out.ll);
        chk("overflow", 56'(overflow_o), 56'(exp_out.ovf));
        chk("count", 56'(cluster_count_o), 56'(exp_out.cnt));
        chk("bc0", 56'(bc0_o), 56'(exp_out.bc0));
        chk("sync_done", 56'(sync_done_o), 56'(exp_out.sd));
    endtask

    // Full sync phase from reset release: exactly 64 sync frames, then an empty RUN frame
    task automatic sync_phase();
        int n_sync;
        n_sync = 0;
        for (int i = 0; i < 66; i++) begin
            run_cycle(all_inv, 1'b0, 1'b0, 1'b0);
            if (link_r_o == {4{14'h2AAA}} && sync_done_o == 1'b0) n_sync++;
        end
        chk("sync_frames", 56'(n_sync), 56'd64);
        chk("first_run_link_r", link_r_o, {4{14'h07FE}});
        chk("first_run_sync_done", 56'(sync_done_o), 56'd1);
        chk("first_run_overflow", 56'(overflow_o), 56'd0);
    endtask

    initial begin
        logic [223:0] c;
        int guard;
        all_inv = {16{14'h07FE}};
        clusters_i = all_inv; overflow_i = 1'b0; bc0_i = 1'b0; test_mode_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_40);
        chk("reset_link_r", link_r_o, 56'd0);
        chk("reset_sync_done", 56'(sync_done_o), 56'd0);
        reset_n = 1'b1;

        sync_phase();

        // Inputs 2, 5, 9 valid
        c = all_inv;
        c[2*14 +: 14] = 14'h080A; c[5*14 +: 14] = 14'h0814; c[9*14 +: 14] = 14'h081E;
        run_cycle(c, 1'b0, 1'b0, 1'b0);
        run_cycle(all_inv, 1'b0, 1'b0, 1'b0);
        chk("pack3_link_r", link_r_o, {14'h07FE, 14'h081E, 14'h0814, 14'h080A});
        chk("pack3_link_l", link_l_o, {4{14'h07FE}});
        chk("pack3_count", 56'(cluster_count_o), 56'd3);

        // All 16 valid, then 8 valid, then none valid with upstream overflow
        for (int k = 0; k < 16; k++) c[k*14 +: 14] = {3'd0, 11'(k)};
        run_cycle(c, 1'b0, 1'b0, 1'b0);
        for (int k = 8; k < 16; k++) c[k*14 +: 14] = 14'h07FE;
        run_cycle(c, 1'b0, 1'b0, 1'b0);
        chk("full_link_r", link_r_o, {14'd3, 14'd2, 14'd1, 14'd0});
        chk("full_link_l", link_l_o, {14'd7, 14'd6, 14'd5, 14'd4});
        chk("full_count", 56'(cluster_count_o), 56'd16);
        chk("full_overflow", 56'(overflow_o), 56'd1);
        run_cycle(all_inv, 1'b1, 1'b0, 1'b0);
        chk("eight_overflow", 56'(overflow_o), 56'd0);
        run_cycle(all_inv, 1'b0, 1'b0, 1'b0);
        chk("upstream_overflow", 56'(overflow_o), 56'd1);

        // bc0 with test mode entry, then back to clusters
        run_cycle(rand_clusters(50), 1'b0, 1'b1, 1'b1);
        run_cycle(all_inv, 1'b0, 1'b0, 1'b1);
        chk("bc0_aligned", 56'(bc0_o), 56'd1);
        run_cycle(all_inv, 1'b0, 1'b0, 1'b1);
        chk("test_bx0", link_r_o, {4{14'd0}});
        run_cycle(all_inv, 1'b0, 1'b0, 1'b1);
        chk("test_bx1", link_l_o, {4{14'd1}});
        for (int i = 0; i < 6; i++) run_cycle(rand_clusters(60), 1'b0, 1'b0, (i < 3) ? 1'b1 : 1'b0);

        // Random traffic with mode toggling
        tm = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) tm = ~tm;
            run_cycle(rand_clusters(30 * int'($urandom_range(0, 3))),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0), tm);
        end

        // BX wrap at 3563
        run_cycle(all_inv, 1'b0, 1'b0, 1'b1);
        run_cycle(all_inv, 1'b0, 1'b0, 1'b1);
        guard = 0;
        while (mbx != 3563 && guard < 5000) begin
            run_cycle(rand_clusters(40), 1'b0, 1'b0, 1'b1);
            guard++;
        end
        if (guard >= 5000) begin
            checks++; errors++;
            $display("FAIL bx_wrap_reach: model never reached 3563");
        end
        run_cycle(all_inv, 1'b0, 1'b0, 1'b1);
        run_cycle(all_inv, 1'b0, 1'b0, 1'b1);
        chk("bx_last", link_r_o, {4{14'd3563}});
        run_cycle(all_inv, 1'b0, 1'b0, 1'b1);
        chk("bx_wrap", link_r_o, {4{14'd0}});

        // bc0 at BX 100
        guard = 0;
        while (mbx != 100 && guard < 200) begin
            run_cycle(all_inv, 1'b0, 1'b0, 1'b1);
            guard++;
        end
        run_cycle(all_inv, 1'b0, 1'b1, 1'b1);
        run_cycle(all_inv, 1'b0, 1'b0, 1'b1);
        chk("bx_100", link_r_o, {4{14'd100}});
        run_cycle(all_inv, 1'b0, 1'b0, 1'b1);
        chk("bx_bc0_clear", link_l_o, {4{14'd0}});

        // Reset mid-RUN clears outputs at once and replays the sync phase
        for (int i = 0; i < 5; i++) run_cycle(rand_clusters(70), 1'b1, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_link_r", link_r_o, 56'd0);
        chk("async_rst_link_l", link_l_o, 56'd0);
        chk("async_rst_count", 56'(cluster_count_o), 56'd0);
        chk("async_rst_overflow", 56'(overflow_o), 56'd0);
        chk("async_rst_sync_done", 56'(sync_done_o), 56'd0);
        model_reset();
        @(negedge clk_40);
        reset_n = 1'b1;
        sync_phase();
        for (int i = 0; i < 20; i++) run_cycle(rand_clusters(80), 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
